// File: rtl/cmd_frame_builder_if.sv
// Handshake/bus bundle between the command frame builder and its neighbours:
// the requester (start/cmd_index/cmd_arg) and the serializer
// (ser_parallel/ser_enable/ser_complete).
interface cmd_frame_builder_if #(
  parameter int n = 8
);
  logic           start;
  logic [5:0]     cmd_index;
  logic [31:0]    cmd_arg;
  logic           ser_complete;
  logic [n-1:0]   ser_parallel;
  logic           ser_enable;
  logic           busy;
  logic           done;

  modport master (
    output start, cmd_index, cmd_arg, ser_complete,
    input  ser_parallel, ser_enable, busy, done
  );

  modport slave (
    input  start, cmd_index, cmd_arg, ser_complete,
    output ser_parallel, ser_enable, busy, done
  );
endinterface

// File: rtl/cmd_frame_builder.sv
// SD command frame builder: latches an index/argument, computes the CRC-7
// serially over the 40 header bits, then hands the 6-byte frame to a
// parallel-to-serial stage one byte at a time with a one-cycle gap between
// bytes and a one-cycle done pulse at the end.
module cmd_frame_builder #(
  parameter int n = 8
) (
  input  logic               sd_clock,
  input  logic               reset,
  cmd_frame_builder_if.slave bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CRC  = 3'd1;
  localparam logic [2:0] SEND = 3'd2;
  localparam logic [2:0] GAP  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]   state;
  logic [5:0]   bit_cnt;
  logic [2:0]   byte_cnt;
  logic [6:0]   crc;
  logic [5:0]   idx_q;
  logic [31:0]  arg_q;

  logic [39:0]  frame_head;
  logic [5:0]   bit_pos;
  logic         frame_bit;
  logic         crc_fb;
  logic [6:0]   crc_next;
  logic [n-1:0] frame_byte;

  logic         ser_enable_q;
  logic [n-1:0] ser_parallel_q;
  logic         busy_q;
  logic         done_q;

  assign bus.ser_enable   = ser_enable_q;
  assign bus.ser_parallel = ser_parallel_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

  // Next CRC value for the current header bit (MSB first) and the frame byte
  // selected by the byte counter.
  always_comb begin
    frame_head = {2'b01, idx_q, arg_q};
    bit_pos    = 6'd39 - bit_cnt;
    frame_bit  = frame_head[bit_pos];
    crc_fb     = frame_bit ^ crc[6];
    crc_next   = {crc[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
    case (byte_cnt)
      3'd0:    frame_byte = {2'b01, idx_q};
      3'd1:    frame_byte = arg_q[31:24];
      3'd2:    frame_byte = arg_q[23:16];
      3'd3:    frame_byte = arg_q[15:8];
      3'd4:    frame_byte = arg_q[7:0];
      3'd5:    frame_byte = {crc, 1'b1};
      default: frame_byte = '0;
    endcase
  end

  // Frame sequencer. Outputs are registered; the first SEND cycle loads the
  // byte and raises ser_enable, and GAP preloads the next byte so the
  // ser_enable low time between bytes is exactly one cycle.
  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      byte_cnt       <= '0;
      crc            <= '0;
      idx_q          <= '0;
      arg_q          <= '0;
      ser_enable_q   <= 1'b0;
      ser_parallel_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            idx_q    <= bus.cmd_index;
            arg_q    <= bus.cmd_arg;
            crc      <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            busy_q   <= 1'b1;
            state    <= CRC;
          end
        end
        CRC: begin
          crc <= crc_next;
          if (bit_cnt == 6'd39) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            state    <= SEND;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        SEND: begin
          if (!ser_enable_q) begin
            ser_enable_q   <= 1'b1;
            ser_parallel_q <= frame_byte;
          end else if (bus.ser_complete) begin
            ser_enable_q   <= 1'b0;
            ser_parallel_q <= '0;
            if (byte_cnt < 3'd5) begin
              byte_cnt <= byte_cnt + 3'd1;
              state    <= GAP;
            end else begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= DONE;
            end
          end
        end
        GAP: begin
          ser_enable_q   <= 1'b1;
          ser_parallel_q <= frame_byte;
          state          <= SEND;
        end
        DONE: begin
          byte_cnt <= '0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_frame_builder.sv
// Self-checking bench for cmd_frame_builder: directed command frames with a
// frame model built from polynomial long division, a per-cycle output monitor
// and literal byte sequences for well-known SD commands.
module tb_cmd_frame_builder;

  logic clk = 1'b0;
  logic reset = 1'b1;

  cmd_frame_builder_if #(.n(8)) bus_if ();

  cmd_frame_builder #(.n(8)) dut (
    .sd_clock (clk),
    .reset    (reset),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state written by the driver, read by the monitor.
  logic [7:0] exp_frame [6];
  int         frame_id = 0;
  bit         mon_on = 1'b0;

  // Monitor state (written only by the monitor).
  int         mon_frame = 0;
  int         pos = 0;
  int         low_run = 0;
  bit         prev_en = 1'b0;
  logic [7:0] last_byte = '0;
  logic [7:0] got [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // CRC-7 as the remainder of (message * x^7) divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_div(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] head;
    head = {2'b01, idx, arg};
    return {head, crc7_div(head), 1'b1};
  endfunction

  // Per-cycle compare against the model: byte value while enabled, zero
  // while not, one-cycle gaps, and done exactly after the sixth byte.
  initial begin
    bit en;
    bit fell;
    forever begin
      @(negedge clk);
      if (mon_frame != frame_id) begin
        mon_frame = frame_id;
        pos = 0;
        low_run = 0;
        prev_en = 1'b0;
        got.delete();
      end
      if (mon_on) begin
        en = bus_if.ser_enable;
        fell = prev_en && !en;
        if (fell) begin
          got.push_back(last_byte);
          pos++;
        end
        if (en) begin
          if (!prev_en && pos > 0) check("gap_len", low_run, 1);
          if (pos < 6) check("byte", bus_if.ser_parallel, exp_frame[pos]);
          else check("extra_byte", pos, 5);
          last_byte = bus_if.ser_parallel;
          low_run = 0;
        end else begin
          check("idle_zero", bus_if.ser_parallel, 8'h00);
          low_run++;
        end
        check("done", bus_if.done, fell && pos == 6);
        prev_en = en;
      end
    end
  end

  // mode: 0 normal, 1 extra start pulses mid-frame, 2 ser_complete noise
  // in IDLE/CRC, 3 reset while B3 is presented.
  task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg,
                           input int delay, input logic [47:0] lit, input int mode);
    logic [47:0] mf;
    logic [47:0] seq;
    int k;
    int t;
    mf = model_frame(idx, arg);
    check("model_pin", mf, lit);
    for (int b = 0; b < 6; b++) exp_frame[b] = mf[47 - 8*b -: 8];
    frame_id++;
    mon_on = 1'b1;
    if (mode == 2) begin
      @(negedge clk) bus_if.ser_complete = 1'b1;
      @(negedge clk) bus_if.ser_complete = 1'b0;
      check("idle_noise_busy", bus_if.busy, 1'b0);
    end
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.cmd_index = idx;
    bus_if.cmd_arg = arg;
    @(negedge clk);
    bus_if.start = 1'b0;
    check("busy_set", bus_if.busy, 1'b1);
    k = 0;
    while (!bus_if.ser_enable && k < 100) begin
      @(negedge clk);
      k++;
      if (mode == 1 && k == 10) begin
        bus_if.start = 1'b1;
        bus_if.cmd_index = 6'h3F;
        bus_if.cmd_arg = 32'hFFFF_FFFF;
      end else if (mode == 1 && k == 11) begin
        bus_if.start = 1'b0;
      end
      if (mode == 2) bus_if.ser_complete = (k == 5 || k == 20);
    end
    bus_if.ser_complete = 1'b0;
    check("latency", k, 41);
    for (int b = 0; b < 6; b++) begin
      t = 0;
      while (!bus_if.ser_enable && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!bus_if.ser_enable) begin
        check("enable_timeout", 0, 1);
        return;
      end
      if (mode == 3 && b == 3) begin
        mon_on = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("abort_en", bus_if.ser_enable, 1'b0);
        check("abort_par", bus_if.ser_parallel, 8'h00);
        check("abort_busy", bus_if.busy, 1'b0);
        check("abort_done", bus_if.done, 1'b0);
        reset = 1'b0;
        return;
      end
      repeat (delay) @(negedge clk);
      if (mode == 1 && b == 2) begin
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
      end
      bus_if.ser_complete = 1'b1;
      @(negedge clk);
      bus_if.ser_complete = 1'b0;
      if (b == 5) begin
        check("done_pulse", bus_if.done, 1'b1);
        check("done_busy", bus_if.busy, 1'b0);
        @(negedge clk);
        check("done_width", bus_if.done, 1'b0);
      end
    end
    if (mode == 1) repeat (60) @(negedge clk);
    check("byte_count", got.size(), 6);
    seq = '0;
    foreach (got[i]) seq = {seq[39:0], got[i]};
    check("sequence", seq, lit);
    check("idle_busy", bus_if.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.start = 1'b0;
    bus_if.cmd_index = '0;
    bus_if.cmd_arg = '0;
    bus_if.ser_complete = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_en", bus_if.ser_enable, 1'b0);
    check("rst_par", bus_if.ser_parallel, 8'h00);
    check("rst_busy", bus_if.busy, 1'b0);
    check("rst_done", bus_if.done, 1'b0);

    run_frame(6'd0,  32'h0000_0000, 0,  48'h40_00_00_00_00_95, 0);
    run_frame(6'd8,  32'h0000_01AA, 2,  48'h48_00_00_01_AA_87, 0);
    run_frame(6'd55, 32'h0000_0000, 1,  48'h77_00_00_00_00_65, 0);
    run_frame(6'd17, 32'h0000_0000, 20, 48'h51_00_00_00_00_55, 0);
    run_frame(6'd8,  32'h0000_01AA, 3,  48'h48_00_00_01_AA_87, 1);
    run_frame(6'd0,  32'h0000_0000, 0,  48'h40_00_00_00_00_95, 2);
    run_frame(6'd8,  32'h0000_01AA, 2,  48'h48_00_00_01_AA_87, 3);
    run_frame(6'd0,  32'h0000_0000, 0,  48'h40_00_00_00_00_95, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
